// File: rtl/serial_adder_if.sv
// Host-side bundle for the bit-serial adder: launch request, operands and registered result.
// START is only honoured while the adder is idle; it is never queued.
`timescale 1ns/1ps
interface serial_adder_if #(
   parameter int WIDTH = 8
);
   logic             START;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             CIN;
   logic             BUSY;
   logic             DONE;
   logic [WIDTH-1:0] SUM;
   logic             COUT;

   modport master (
      output START, A, B, CIN,
      input  BUSY, DONE, SUM, COUT
   );

   modport slave (
      input  START, A, B, CIN,
      output BUSY, DONE, SUM, COUT
   );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder, one full-adder bit per clock, LSB first; DONE pulses WIDTH+1 edges after acceptance.
// START is only sampled in IDLE; requests while busy or done are dropped, issue interval is WIDTH+2 cycles.
`timescale 1ns/1ps
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic          CLKIN,
   input  logic          RESET,
   serial_adder_if.slave bus
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] sha, sha_nxt;
   logic [WIDTH-1:0] shb, shb_nxt;
   logic [WIDTH-1:0] shs, shs_nxt;
   logic [WIDTH-1:0] sum_q, sum_nxt;
   logic             carry, carry_nxt;
   logic             cout_q, cout_nxt;
   logic [CW-1:0]    cnt, cnt_nxt;
   logic             bit_s;
   logic             bit_c;

   assign bit_s = sha[0] ^ shb[0] ^ carry;
   assign bit_c = (sha[0] & shb[0]) | (sha[0] & carry) | (shb[0] & carry);

   always_ff @(posedge CLKIN) begin
      if (RESET) begin
         state  <= S_IDLE;
         sha    <= '0;
         shb    <= '0;
         shs    <= '0;
         sum_q  <= '0;
         carry  <= 1'b0;
         cout_q <= 1'b0;
         cnt    <= '0;
      end else begin
         state  <= state_nxt;
         sha    <= sha_nxt;
         shb    <= shb_nxt;
         shs    <= shs_nxt;
         sum_q  <= sum_nxt;
         carry  <= carry_nxt;
         cout_q <= cout_nxt;
         cnt    <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      sha_nxt   = sha;
      shb_nxt   = shb;
      shs_nxt   = shs;
      sum_nxt   = sum_q;
      carry_nxt = carry;
      cout_nxt  = cout_q;
      cnt_nxt   = cnt;
      case (state)
         S_IDLE: begin
            if (bus.START) begin
               sha_nxt   = bus.A;
               shb_nxt   = bus.B;
               carry_nxt = bus.CIN;
               shs_nxt   = '0;
               cnt_nxt   = '0;
               state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            // Sum bits enter at the MSB so after WIDTH shifts bit 0 holds the LSB result.
            shs_nxt   = (shs >> 1) | (WIDTH'(bit_s) << (WIDTH - 1));
            sha_nxt   = sha >> 1;
            shb_nxt   = shb >> 1;
            carry_nxt = bit_c;
            cnt_nxt   = cnt + CW'(1);
            if (cnt == LAST) begin
               sum_nxt   = shs_nxt;
               cout_nxt  = bit_c;
               state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   assign bus.BUSY = (state == S_RUN);
   assign bus.DONE = (state == S_DONE);
   assign bus.SUM  = sum_q;
   assign bus.COUT = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: 8-bit and 1-bit builds against hand-computed results.
`timescale 1ns/1ps
module tb_serial_adder;
   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;

   serial_adder_if #(.WIDTH(8)) bus8();
   serial_adder_if #(.WIDTH(1)) bus1();

   serial_adder #(.WIDTH(8)) dut8 (.CLKIN(clk), .RESET(rst), .bus(bus8));
   serial_adder #(.WIDTH(1)) dut1 (.CLKIN(clk), .RESET(rst), .bus(bus1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Launches one 8-bit op and watches 20 cycles; optionally disturbs inputs mid-run.
   task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic cin, input logic [7:0] exp_sum, input logic exp_cout,
                         input bit disturb);
      int busy_cnt = 0;
      int done_cnt = 0;
      int done_at  = 0;
      @(negedge clk);
      bus8.A = a; bus8.B = b; bus8.CIN = cin; bus8.START = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (k == 1) bus8.START = 1'b0;
         if (bus8.BUSY) busy_cnt++;
         if (bus8.DONE) begin
            done_cnt++;
            if (done_at == 0) done_at = k;
         end
         if (disturb && k == 3) begin
            bus8.A = ~a; bus8.B = ~b; bus8.CIN = ~cin; bus8.START = 1'b1;
         end
         if (disturb && k == 4) bus8.START = 1'b0;
      end
      check({tag, "_busy_cycles"}, busy_cnt, 8);
      check({tag, "_done_pulses"}, done_cnt, 1);
      check({tag, "_done_edge"}, done_at, 9);
      check({tag, "_sum"}, bus8.SUM, exp_sum);
      check({tag, "_cout"}, bus8.COUT, exp_cout);
   endtask

   task automatic run_w1(input int idx, input logic exp_sum, input logic exp_cout);
      int busy_cnt = 0;
      int done_at  = 0;
      logic [2:0] v;
      v = idx[2:0];
      @(negedge clk);
      bus1.A = v[2]; bus1.B = v[1]; bus1.CIN = v[0]; bus1.START = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         if (k == 1) bus1.START = 1'b0;
         if (bus1.BUSY) busy_cnt++;
         if (bus1.DONE && done_at == 0) done_at = k;
      end
      check($sformatf("w1_%0d_busy", idx), busy_cnt, 1);
      check($sformatf("w1_%0d_done_edge", idx), done_at, 2);
      check($sformatf("w1_%0d_sum", idx), bus1.SUM, exp_sum);
      check($sformatf("w1_%0d_cout", idx), bus1.COUT, exp_cout);
   endtask

   initial begin
      logic [7:0] w1_sum_tab;
      logic [7:0] w1_cout_tab;
      logic [7:0] b2b_a [3];
      logic [7:0] b2b_b [3];
      logic       b2b_c [3];
      logic [7:0] b2b_s [3];
      logic       b2b_co[3];
      int         done_cnt;
      int         last_done;
      int         idx;

      n_checks = 0;
      n_errors = 0;
      rst = 1'b1;
      bus8.START = 1'b0; bus8.A = '0; bus8.B = '0; bus8.CIN = 1'b0;
      bus1.START = 1'b0; bus1.A = '0; bus1.B = '0; bus1.CIN = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_busy", bus8.BUSY, 0);
      check("rst_done", bus8.DONE, 0);
      check("rst_sum", bus8.SUM, 0);
      check("rst_cout", bus8.COUT, 0);
      rst = 1'b0;

      run_op("op5a33", 8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 1'b0);
      run_op("opff01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
      run_op("opffff", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
      run_op("op0000", 8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0);
      run_op("disturb", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b1);

      // Reset asserted so that edge E4 after acceptance samples it.
      @(negedge clk);
      bus8.A = 8'h0F; bus8.B = 8'h01; bus8.CIN = 1'b0; bus8.START = 1'b1;
      @(negedge clk);
      bus8.START = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst_busy", bus8.BUSY, 0);
      check("midrst_done", bus8.DONE, 0);
      check("midrst_sum", bus8.SUM, 0);
      check("midrst_cout", bus8.COUT, 0);
      done_cnt = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (bus8.DONE) done_cnt++;
      end
      check("midrst_no_done", done_cnt, 0);
      run_op("after_rst", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);

      w1_sum_tab  = 8'h96;
      w1_cout_tab = 8'hE8;
      for (int i = 0; i < 8; i++) run_w1(i, w1_sum_tab[i], w1_cout_tab[i]);

      b2b_a = '{8'h12, 8'h80, 8'h7F};
      b2b_b = '{8'h34, 8'h80, 8'h00};
      b2b_c = '{1'b0, 1'b0, 1'b1};
      b2b_s = '{8'h46, 8'h00, 8'h80};
      b2b_co = '{1'b0, 1'b1, 1'b0};
      @(negedge clk);
      idx = 0;
      last_done = 0;
      bus8.A = b2b_a[0]; bus8.B = b2b_b[0]; bus8.CIN = b2b_c[0]; bus8.START = 1'b1;
      for (int k = 1; k <= 40 && idx < 3; k++) begin
         @(negedge clk);
         if (bus8.DONE) begin
            check($sformatf("b2b_%0d_sum", idx), bus8.SUM, b2b_s[idx]);
            check($sformatf("b2b_%0d_cout", idx), bus8.COUT, b2b_co[idx]);
            check($sformatf("b2b_%0d_edge", idx), k - last_done, (idx == 0) ? 9 : 10);
            last_done = k;
            idx++;
            if (idx < 3) begin
               bus8.A = b2b_a[idx]; bus8.B = b2b_b[idx]; bus8.CIN = b2b_c[idx];
            end else begin
               bus8.START = 1'b0;
            end
         end else if (idx > 0) begin
            check($sformatf("b2b_%0d_hold", idx - 1), {bus8.COUT, bus8.SUM},
                  {b2b_co[idx-1], b2b_s[idx-1]});
         end
      end
      check("b2b_ops_completed", idx, 3);
      bus8.START = 1'b0;
      repeat (2) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
